// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-bank write-port scheduler.
// onehot_dec masks r0 so the hardwired register can never be enabled or marked busy.
package regfile_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;
    localparam int NREQ = 2;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] addr);
        logic [NREG-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        oh[0]    = 1'b0;
        return oh;
    endfunction

    // First requester at or after ptr, wrapping; a zero ptr gives lowest-index priority.
    function automatic logic [NREQ-1:0] pick_rr(input logic [NREQ-1:0] req,
                                                input logic [PW-1:0]   ptr);
        logic [NREQ-1:0] g;
        logic            found;
        int              idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Writeback requester arbiter: round-robin when REGWB_ROUND_ROBIN_EN is defined, else fixed priority.
// Latency: grant is combinational from Req and pointer; pointer advances at the edge after a grant.
// Backpressure: ungranted requesters simply hold Req; grant is forced low while Rst is high.
module rr_arbiter
    import regfile_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NREQ-1:0] Req,
    output logic [NREQ-1:0] Gnt
);

`ifdef REGWB_ROUND_ROBIN_EN
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    always_comb begin
        Gnt     = Rst ? '0 : pick_rr(Req, ptr);
        ptr_nxt = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (Gnt[i]) begin
                ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
`else
    // Fixed priority is purely combinational, so the clock has no load here.
    logic unused_clk;
    assign unused_clk = Clk;

    always_comb begin
        Gnt = Rst ? '0 : pick_rr(Req, '0);
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register bank write port among NREQ writeback requesters and tracks busy registers.
// Latency: grant in cycle t drives D/En during t+1; policy set by REGWB_ROUND_ROBIN_EN.
// Backpressure: one grant per cycle, requesters hold until granted; r0 writes consume a slot with En=0.
module regfile_wb_arbiter #(
    parameter int NREQ = regfile_pkg::NREQ,
    parameter int DW   = regfile_pkg::DW,
    parameter int AW   = regfile_pkg::AW,
    parameter int NREG = regfile_pkg::NREG
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*AW-1:0]   ReqAddr,
    input  logic [NREQ*DW-1:0]   ReqData,
    output logic [NREQ-1:0]      Gnt,
    input  logic                 Resv,
    input  logic [AW-1:0]        ResvAddr,
    output logic [NREG-1:0]      Busy,
    output logic [DW-1:0]        D,
    output logic [NREG-1:0]      En
);
    import regfile_pkg::*;

    logic [NREQ-1:0] gnt;
    logic            any_gnt;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] busy_set;

    rr_arbiter u_arb (
        .Clk (Clk),
        .Rst (Rst),
        .Req (Req),
        .Gnt (gnt)
    );

    assign Gnt = gnt;

    always_comb begin
        any_gnt  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                any_gnt  = 1'b1;
                sel_addr = ReqAddr[i*AW +: AW];
                sel_data = ReqData[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            D  <= '0;
            En <= '0;
        end else begin
            En <= any_gnt ? onehot_dec(sel_addr) : '0;
            if (any_gnt) begin
                D <= sel_data;
            end
        end
    end

    // A new reservation landing on the register being written keeps it busy.
    assign busy_set = Resv ? onehot_dec(ResvAddr) : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Busy <= '0;
        end else begin
            Busy <= (Busy & ~En) | busy_set;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention, r0, set/clear collision, throughput.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic                 resv;
    logic [AW-1:0]        resv_addr;
    logic [NREG-1:0]      busy;
    logic [DW-1:0]        d;
    logic [NREG-1:0]      en;

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter dut (
        .Clk      (clk),
        .Rst      (rst),
        .Req      (req),
        .ReqAddr  (req_addr),
        .ReqData  (req_data),
        .Gnt      (gnt),
        .Resv     (resv),
        .ResvAddr (resv_addr),
        .Busy     (busy),
        .D        (d),
        .En       (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    logic [1:0]  exp_gnt [4];
    logic [31:0] exp_en  [4];

    initial begin
`ifdef REGWB_ROUND_ROBIN_EN
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_en  = '{32'h0000_0200, 32'h0000_0400, 32'h0000_0200, 32'h0000_0400};
`else
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_en  = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0200, 32'h0000_0200};
`endif
        rst       = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_data  = '0;
        resv      = 1'b0;
        resv_addr = '0;
        tick();
        tick();

        // reset state
        chk("rst_d",    d,    32'h0);
        chk("rst_en",   en,   32'h0);
        chk("rst_busy", busy, 32'h0);
        req = 2'b01;
        #1;
        chk("gnt_in_rst", 32'(gnt), 32'h0);

        // reset mid-write
        rst = 1'b0; req = '0; resv = 1'b1; resv_addr = 5'd5;
        tick();
        chk("busy5_set", busy, 32'h0000_0020);
        resv = 1'b0;
        req = 2'b01; req_addr[0 +: AW] = 5'd5; req_data[0 +: DW] = 32'hDEAD_BEEF;
        #1;
        chk("gnt_r5", 32'(gnt), 32'h1);
        rst = 1'b1;
        #1;
        chk("gnt_r5_rst", 32'(gnt), 32'h0);
        tick();
        chk("rstw_en",   en,   32'h0);
        chk("rstw_d",    d,    32'h0);
        chk("rstw_busy", busy, 32'h0);
        tick();
        chk("rstw_en2", en, 32'h0);
        rst = 1'b0; req = '0;
        tick();
        chk("r5_never", en, 32'h0);

        // single write from requester 1
        resv = 1'b1; resv_addr = 5'd7;
        tick();
        chk("busy7_set", busy, 32'h0000_0080);
        resv = 1'b0;
        req = 2'b10; req_addr[AW +: AW] = 5'd7; req_data[DW +: DW] = 32'h1234_5678;
        #1;
        chk("gnt1", 32'(gnt), 32'h2);
        tick();
        chk("w7_d",    d,    32'h1234_5678);
        chk("w7_en",   en,   32'h0000_0080);
        chk("w7_busy", busy, 32'h0000_0080);
        req = '0;
        tick();
        chk("w7_busy_clr", busy, 32'h0);
        chk("w7_en_idle",  en,   32'h0);
        chk("w7_d_hold",   d,    32'h1234_5678);

        // contention
        req = 2'b11;
        req_addr[0 +: AW] = 5'd9;  req_data[0 +: DW]  = 32'hAAAA_0009;
        req_addr[AW +: AW] = 5'd10; req_data[DW +: DW] = 32'hBBBB_000A;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("cont_gnt%0d", c), 32'(gnt), 32'(exp_gnt[c]));
            tick();
            chk($sformatf("cont_en%0d", c), en, exp_en[c]);
        end
        req = '0;
        tick();

        // r0 write and r0 reservation
        req = 2'b01; req_addr[0 +: AW] = 5'd0; req_data[0 +: DW] = 32'hFFFF_FFFF;
        #1;
        chk("r0_gnt", 32'(gnt), 32'h1);
        tick();
        chk("r0_en", en, 32'h0);
        chk("r0_d",  d,  32'hFFFF_FFFF);
        req = '0; resv = 1'b1; resv_addr = 5'd0;
        tick();
        chk("r0_busy", busy, 32'h0);
        resv = 1'b0;

        // set/clear collision on r3
        resv = 1'b1; resv_addr = 5'd3;
        tick();
        chk("busy3_set", busy, 32'h0000_0008);
        resv = 1'b0;
        req = 2'b01; req_addr[0 +: AW] = 5'd3; req_data[0 +: DW] = 32'h0000_0033;
        tick();
        chk("w3_en", en, 32'h0000_0008);
        req = '0; resv = 1'b1; resv_addr = 5'd3;
        tick();
        chk("coll_busy", busy, 32'h0000_0008);
        resv = 1'b0;
        tick();
        chk("coll_busy_hold", busy, 32'h0000_0008);
        req = 2'b01;
        tick();
        req = '0;
        tick();
        chk("busy3_clr", busy, 32'h0);

        // throughput: 8 back-to-back writes
        req = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            req_addr[0 +: AW] = AW'(k);
            req_data[0 +: DW] = 32'h1111_1111 * k;
            #1;
            chk($sformatf("tp_gnt%0d", k), 32'(gnt), 32'h1);
            tick();
            chk($sformatf("tp_en%0d", k), en, 32'h1 << k);
            chk($sformatf("tp_d%0d", k),  d,  32'h1111_1111 * k);
        end
        req = '0;
        tick();
        chk("tp_idle", en, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
